// File: rtl/int_pkg.sv
// int_pkg: shared constants, types and helpers for the interrupt controller.
//   NUM_SRC          number of int_in bits (bit 0 belongs to sysctrl's sys_int)
//   SRC_*            source index constants
//   EDGE_MASK_DEF    default per-bit source mode (1 = rising edge, 0 = level)
//   MASK_RESET_DEF   default mask loaded at reset
//   prio_idx()       lowest-numbered set bit of a vector, 0 when empty
package int_pkg;

  localparam int NUM_SRC = 8;

  localparam int SRC_SYS   = 0;
  localparam int SRC_SDC   = 1;
  localparam int SRC_HID   = 2;
  localparam int SRC_PORT  = 3;
  localparam int SRC_RSVD4 = 4;
  localparam int SRC_RSVD5 = 5;
  localparam int SRC_RSVD6 = 6;
  localparam int SRC_RSVD7 = 7;

  localparam logic [NUM_SRC-1:0] EDGE_MASK_DEF  = 8'hFE;
  localparam logic [NUM_SRC-1:0] MASK_RESET_DEF = 8'hFE;

  typedef logic [NUM_SRC-1:0] int_vec_t;

  // Priority encoder: bit 1 wins over higher bits. Bit 0 is never driven
  // by this block, so an empty vector and "bit 0 only" both give 0.
  function automatic logic [2:0] prio_idx(input int_vec_t v);
    logic [2:0] r_idx;
    r_idx = 3'd0;
    for (int i = NUM_SRC - 1; i >= 1; i--) begin
      if (v[i]) r_idx = 3'(i);
    end
    return r_idx;
  endfunction

endpackage

// File: rtl/int_src_slot.sv
// int_src_slot: state for one interrupt source.
//   clk        system clock
//   reset      synchronous active-high reset
//   src_evt    source event / level input
//   int_ack    acknowledge pulse for this source
//   pending    latched pending bit (before masking)
// Holds the edge-history bit, pending, deferred flag and hold-off counter.
// An ack clears pending and starts a hold-off; edges seen during the
// hold-off are remembered in deferred and released when it expires.
// Level sources are simply re-evaluated once the hold-off has ended.
module int_src_slot #(
  parameter bit IS_EDGE = 1'b1,
  parameter int HOLDOFF = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic src_evt,
  input  logic int_ack,
  output logic pending
);

  localparam int CW = (HOLDOFF == 0) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF);

  logic          r_prev;
  logic          r_pending;
  logic          r_deferred;
  logic [CW-1:0] r_cnt;

  logic w_set;
  logic w_edge_set;

  assign w_set      = IS_EDGE ? (src_evt & ~r_prev) : src_evt;
  // Only edge sources are ever deferred; a level is sampled again later.
  assign w_edge_set = IS_EDGE & w_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev     <= 1'b0;
      r_pending  <= 1'b0;
      r_deferred <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_prev <= src_evt;
      if (int_ack) begin
        // Ack wins over a coincident set, but an edge is not lost.
        r_pending <= 1'b0;
        r_cnt     <= HOLD_LOAD;
        if (w_edge_set) r_deferred <= 1'b1;
      end else if (r_cnt == '0) begin
        // With HOLDOFF=0 a deferred edge lands here one cycle after the ack.
        if (w_set || r_deferred) r_pending <= 1'b1;
        r_deferred <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          // Hold-off expires this cycle: release anything remembered,
          // including an edge arriving on this very cycle.
          if (r_deferred || w_edge_set) r_pending <= 1'b1;
          r_deferred <= 1'b0;
        end else if (w_edge_set) begin
          r_deferred <= 1'b1;
        end
      end
    end
  end

  assign pending = r_pending;

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller feeding sysctrl's int_in vector.
//   clk        system clock
//   reset      synchronous active-high reset
//   src_evt    [7:0] source events/levels (bit 0 ignored)
//   int_ack    [7:0] single-cycle acks from sysctrl (bit 0 ignored)
//   mask_we    mask write strobe
//   mask_data  [7:0] new mask (bit 0 ignored)
//   int_in     [7:0] registered masked pending vector, bit 0 always 0
//   irq_any    OR of int_in
//   irq_idx    [2:0] lowest-numbered set bit of int_in, 0 when none
// Sources 1..7 each get an int_src_slot; this level owns the mask and the
// registered outputs.
module int_ctrl
  import int_pkg::*;
#(
  parameter logic [7:0] EDGE_MASK  = EDGE_MASK_DEF,
  parameter logic [7:0] MASK_RESET = MASK_RESET_DEF,
  parameter int         HOLDOFF    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] src_evt,
  input  logic [7:0] int_ack,
  input  logic       mask_we,
  input  logic [7:0] mask_data,
  output logic [7:0] int_in,
  output logic       irq_any,
  output logic [2:0] irq_idx
);

  int_vec_t   w_pending;
  int_vec_t   w_int_next;
  logic       w_unused_bits;

  int_vec_t   r_mask;
  int_vec_t   r_int_in;
  logic       r_irq_any;
  logic [2:0] r_irq_idx;

  // Bit 0 is sysctrl's own interrupt; nothing here drives it.
  assign w_pending[0]  = 1'b0;
  assign w_unused_bits = src_evt[0] ^ int_ack[0];

  generate
    for (genvar gi = 1; gi < NUM_SRC; gi++) begin : g_slot
      int_src_slot #(
        .IS_EDGE (EDGE_MASK[gi]),
        .HOLDOFF (HOLDOFF)
      ) u_slot (
        .clk     (clk),
        .reset   (reset),
        .src_evt (src_evt[gi]),
        .int_ack (int_ack[gi]),
        .pending (w_pending[gi])
      );
    end
  endgenerate

  assign w_int_next = w_pending & r_mask & 8'hFE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask    <= MASK_RESET & 8'hFE;
      r_int_in  <= '0;
      r_irq_any <= 1'b0;
      r_irq_idx <= 3'd0;
    end else begin
      if (mask_we) r_mask <= mask_data & 8'hFE;
      r_int_in  <= w_int_next;
      r_irq_any <= |w_int_next;
      r_irq_idx <= prio_idx(w_int_next);
    end
  end

  assign int_in  = r_int_in;
  assign irq_any = r_irq_any;
  assign irq_idx = r_irq_idx;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed self-checking bench for int_ctrl.
// Three instances cover the parameter sets the scenarios need:
//   dut_a  HOLDOFF=4,   EDGE_MASK=8'hFA (source 2 is a level source)
//   dut_b  HOLDOFF=0,   default edge sources (coincident ack + mask tests)
//   dut_c  HOLDOFF=255  (reset in the middle of a hold-off)
// Inputs change right after a falling edge; outputs are sampled on falling
// edges, so "nclk(1)" advances exactly one rising edge.
module tb_int_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic       rst_a, we_a, any_a;
  logic [7:0] evt_a, ack_a, md_a, int_a;
  logic [2:0] idx_a;
  logic       rst_b, we_b, any_b;
  logic [7:0] evt_b, ack_b, md_b, int_b;
  logic [2:0] idx_b;
  logic       rst_c, we_c, any_c;
  logic [7:0] evt_c, ack_c, md_c, int_c;
  logic [2:0] idx_c;

  int_ctrl #(.EDGE_MASK(8'hFA), .MASK_RESET(8'hFE), .HOLDOFF(4)) dut_a (
    .clk(clk), .reset(rst_a), .src_evt(evt_a), .int_ack(ack_a),
    .mask_we(we_a), .mask_data(md_a), .int_in(int_a), .irq_any(any_a),
    .irq_idx(idx_a));

  int_ctrl #(.EDGE_MASK(8'hFE), .MASK_RESET(8'hFE), .HOLDOFF(0)) dut_b (
    .clk(clk), .reset(rst_b), .src_evt(evt_b), .int_ack(ack_b),
    .mask_we(we_b), .mask_data(md_b), .int_in(int_b), .irq_any(any_b),
    .irq_idx(idx_b));

  int_ctrl #(.EDGE_MASK(8'hFE), .MASK_RESET(8'hFE), .HOLDOFF(255)) dut_c (
    .clk(clk), .reset(rst_c), .src_evt(evt_c), .int_ack(ack_c),
    .mask_we(we_c), .mask_data(md_c), .int_in(int_c), .irq_any(any_c),
    .irq_idx(idx_c));

  task automatic check_val(input string tag, input logic [7:0] got,
                           input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end else begin
      $display("  ok %s got=%02h", tag, got);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    evt_a = '0; ack_a = '0; we_a = 1'b0; md_a = '0;
    evt_b = '0; ack_b = '0; we_b = 1'b0; md_b = '0;
    evt_c = '0; ack_c = '0; we_c = 1'b0; md_c = '0;

    // Reset state
    nclk(2);
    check_val("rst_int_a", int_a, 8'h00);
    check_val("rst_any_a", {7'd0, any_a}, 8'h00);
    check_val("rst_idx_a", {5'd0, idx_a}, 8'h00);
    check_val("rst_int_c", int_c, 8'h00);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Idle after reset
    nclk(10);
    check_val("idle_int", int_a, 8'h00);
    check_val("idle_idx", {5'd0, idx_a}, 8'h00);
    check_val("idle_any", {7'd0, any_a}, 8'h00);

    // Edge on source 1, then ack, then a deferred second edge (HOLDOFF=4)
    evt_a = 8'h02; nclk(1);
    evt_a = 8'h00; nclk(1);
    check_val("edge_int", int_a, 8'h02);
    check_val("edge_idx", {5'd0, idx_a}, 8'h01);
    check_val("edge_any", {7'd0, any_a}, 8'h01);
    ack_a = 8'h02; nclk(1);
    ack_a = 8'h00; evt_a = 8'h02; nclk(1);
    evt_a = 8'h00;
    check_val("ack_int", int_a, 8'h00);
    for (int k = 0; k < 3; k++) begin
      nclk(1);
      check_val("holdoff_int", int_a, 8'h00);
    end
    nclk(1);
    check_val("deferred_int", int_a, 8'h02);
    ack_a = 8'h02; nclk(1);
    ack_a = 8'h00; nclk(8);
    check_val("clean_a", int_a, 8'h00);

    // Level source 2: ack drops it for 5 cycles, then it reasserts
    evt_a = 8'h04; nclk(2);
    check_val("lvl_int", int_a, 8'h04);
    ack_a = 8'h04; nclk(1);
    ack_a = 8'h00;
    check_val("lvl_ack_lat", int_a, 8'h04);
    for (int k = 0; k < 5; k++) begin
      nclk(1);
      check_val("lvl_holdoff", int_a, 8'h00);
    end
    nclk(1);
    check_val("lvl_reassert", int_a, 8'h04);
    evt_a = 8'h00; nclk(1);
    ack_a = 8'h04; nclk(1);
    ack_a = 8'h00; nclk(1);
    for (int k = 0; k < 8; k++) begin
      check_val("lvl_released", int_a, 8'h00);
      nclk(1);
    end

    // Coincident set and ack on edge source 3 with HOLDOFF=0
    evt_b = 8'h08; nclk(1);
    evt_b = 8'h00; nclk(1);
    check_val("coin_pre", int_b, 8'h08);
    evt_b = 8'h08; ack_b = 8'h08; nclk(1);
    evt_b = 8'h00; ack_b = 8'h00;
    check_val("coin_lat", int_b, 8'h08);
    nclk(1);
    check_val("coin_gap", int_b, 8'h00);
    nclk(1);
    check_val("coin_kept", int_b, 8'h08);
    ack_b = 8'h08; nclk(1);
    ack_b = 8'h00; nclk(2);
    check_val("coin_clear", int_b, 8'h00);

    // Mask: masked source still latches, unmasking exposes it
    we_b = 1'b1; md_b = 8'h00; nclk(1);
    we_b = 1'b0; evt_b = 8'h20; nclk(1);
    evt_b = 8'h00; nclk(2);
    check_val("mask_int", int_b, 8'h00);
    check_val("mask_any", {7'd0, any_b}, 8'h00);
    we_b = 1'b1; md_b = 8'hFE; nclk(1);
    we_b = 1'b0; nclk(1);
    check_val("unmask_int", int_b, 8'h20);
    check_val("unmask_idx", {5'd0, idx_b}, 8'h05);
    evt_b = 8'h08; nclk(1);
    evt_b = 8'h00; nclk(1);
    check_val("prio_int", int_b, 8'h28);
    check_val("prio_idx", {5'd0, idx_b}, 8'h03);

    // Reset in the middle of a hold-off (HOLDOFF=255)
    ack_c = 8'h02; nclk(1);
    ack_c = 8'h00; nclk(20);
    evt_c = 8'h02; nclk(1);
    evt_c = 8'h00; nclk(3);
    check_val("c_holdoff", int_c, 8'h00);
    nclk(130);
    rst_c = 1'b1; nclk(1);
    check_val("c_in_reset", int_c, 8'h00);
    nclk(1);
    rst_c = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nclk(1);
      check_val("c_forgotten", int_c, 8'h00);
    end
    evt_c = 8'h02; nclk(1);
    evt_c = 8'h00;
    check_val("c_post_lat", int_c, 8'h00);
    nclk(1);
    check_val("c_post_int", int_c, 8'h02);
    check_val("c_post_idx", {5'd0, idx_c}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
